polyeta_pack_seq: RTL and testbench

//  Sequences eta-packing of the secret vectors s1||s2 for key generation: reads signed coefficients

---
 rtl/polyeta_pack_seq.sv | 114 +++++++++++
 tb/tb_polyeta_pack_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/polyeta_pack_seq.sv
// rtl/polyeta_pack_seq.sv - eta-packing sequencer: coefficient RAM reads to nibble-packed byte stream
module polyeta_pack_seq #(
  parameter int N      = 256,
  parameter int ETA    = 4,
  parameter int NPOLY  = 11,
  parameter int COEF_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              coef_rd_en,
  output logic [ADDR_W-1:0] coef_rd_addr,
  input  logic [COEF_W-1:0] coef_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last
);

  localparam int NPAIR = NPOLY * N / 2;
  localparam int K_W   = $clog2(NPAIR + 1);
  localparam logic signed [COEF_W-1:0] ETA_POS = COEF_W'(ETA);
  localparam logic signed [COEF_W-1:0] ETA_NEG = -ETA_POS;
  localparam logic [3:0]               ETA_NIB = 4'(ETA);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_LO, S_FETCH_HI, S_LATCH, S_OUT, S_DONE
  } state_t;

  state_t         state;
  logic [K_W-1:0] k;
  logic [K_W-1:0] k_inc;
  logic [3:0]     lo_nib;
  logic [3:0]     rd_nib;
  logic           rd_bad;

  // Only the low nibble of (ETA - c) survives, so a 4-bit subtract is exact.
  always_comb begin
    k_inc  = k + 1'b1;
    rd_nib = ETA_NIB - coef_rd_data[3:0];
    rd_bad = ($signed(coef_rd_data) < ETA_NEG) || ($signed(coef_rd_data) > ETA_POS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      k            <= '0;
      lo_nib       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_range    <= 1'b0;
      coef_rd_en   <= 1'b0;
      coef_rd_addr <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k            <= '0;
            err_range    <= 1'b0;
            busy         <= 1'b1;
            coef_rd_en   <= 1'b1;
            coef_rd_addr <= '0;
            state        <= S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          coef_rd_addr <= ADDR_W'({k, 1'b1});
          state        <= S_FETCH_HI;
        end
        S_FETCH_HI: begin
          lo_nib     <= rd_nib;
          coef_rd_en <= 1'b0;
          if (rd_bad) err_range <= 1'b1;
          state      <= S_LATCH;
        end
        S_LATCH: begin
          out_data  <= {rd_nib, lo_nib};
          out_last  <= (k == K_W'(NPAIR - 1));
          out_valid <= 1'b1;
          if (rd_bad) err_range <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              k            <= k_inc;
              coef_rd_en   <= 1'b1;
              coef_rd_addr <= ADDR_W'({k_inc, 1'b0});
              state        <= S_FETCH_LO;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_polyeta_pack_seq.sv
// tb/tb_polyeta_pack_seq.sv - directed self-checking bench for polyeta_pack_seq
module tb_polyeta_pack_seq;

  localparam int NCOEF = 2816;
  localparam int NPAIR = 1408;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err_range, coef_rd_en;
  logic [11:0] coef_rd_addr;
  logic [31:0] coef_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;

  logic signed [31:0] mem [0:NCOEF-1];
  int          n_vec = 0;
  int          n_miss = 0;
  int          max_addr = 0;

  logic [7:0]  got_q [$];
  bit          last_q [$];
  int          first_valid, done_cyc, done_cnt;
  logic        err_at1;

  polyeta_pack_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err_range(err_range), .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr),
    .coef_rd_data(coef_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // One-cycle-latency coefficient RAM
  always @(posedge clk) begin
    if (coef_rd_en) begin
      coef_rd_data <= mem[coef_rd_addr];
      if (int'(coef_rd_addr) > max_addr) max_addr <= int'(coef_rd_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int i);
    logic [31:0] a, b;
    a = 32'd4 - mem[2*i];
    b = 32'd4 - mem[2*i+1];
    return {b[3:0], a[3:0]};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < NCOEF; i++) mem[i] = 0;
  endtask

  // Cycle 0 is the edge that samples start; observation at cycle c happens on the negedge inside it.
  task automatic run_pass(input int rdy_pct, input bit mid_start);
    int cyc;
    bit holding;
    logic [8:0] held;
    got_q.delete();
    last_q.delete();
    first_valid = -1; done_cyc = -1; done_cnt = 0;
    holding = 0; held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    err_at1 = err_range;
    while (cyc < 20000) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (holding) check("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!busy) break;
      out_ready = ($urandom_range(99) < rdy_pct);
      start = (mid_start && (cyc == 50 || cyc == 3000));
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        last_q.push_back(out_last);
        holding = 0;
      end else begin
        holding = out_valid;
        held = {out_last, out_data};
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) check("pass_timeout", 32'(cyc), 32'd0);
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic check_stream(input string tag);
    int bad;
    int nlast;
    bad = 0; nlast = 0;
    check({tag, "_count"}, 32'(got_q.size()), 32'(NPAIR));
    for (int i = 0; i < got_q.size() && i < NPAIR; i++) begin
      if (got_q[i] !== model_byte(i)) bad++;
      if (last_q[i]) nlast++;
    end
    check({tag, "_bad_bytes"}, 32'(bad), 32'd0);
    check({tag, "_nlast"}, 32'(nlast), 32'd1);
    if (last_q.size() > 0) check({tag, "_last_pos"}, 32'(last_q[last_q.size()-1]), 32'd1);
    check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    clear_mem();
    repeat (3) @(negedge clk);
    check("rst_outputs", 32'({busy, done, err_range, coef_rd_en, out_valid, out_last}), 32'd0);
    check("rst_data_addr", 32'({out_data, coef_rd_addr}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // All zero coefficients, no backpressure
    run_pass(100, 0);
    check_stream("t1");
    check("t1_byte0", 32'(got_q[0]), 32'h44);
    check("t1_byte_last", 32'(got_q[NPAIR-1]), 32'h44);
    check("t1_first_valid", 32'(first_valid), 32'd4);
    check("t1_done_cycle", 32'(done_cyc), 32'd5633);
    check("t1_err", 32'(err_range), 32'd0);

    // Mixed legal values under random backpressure
    mem[0] = 4; mem[1] = -4; mem[2] = -1; mem[3] = 3;
    for (int i = 4; i < NCOEF; i++) mem[i] = $signed(32'($urandom_range(8))) - 4;
    run_pass(40, 0);
    check_stream("t23");
    check("t2_byte0", 32'(got_q[0]), 32'h80);
    check("t2_byte1", 32'(got_q[1]), 32'h15);
    check("t2_first_valid", 32'(first_valid), 32'd4);
    check("t2_err", 32'(err_range), 32'd0);

    // Out-of-range coefficient: sticky error, byte still emitted
    clear_mem();
    mem[5] = 5;
    run_pass(100, 0);
    check_stream("t4");
    check("t4_byte2", 32'(got_q[2]), 32'hF4);
    check("t4_err_sticky", 32'(err_range), 32'd1);

    // Next start clears the error; start pulses mid-pass are ignored
    clear_mem();
    run_pass(100, 1);
    check_stream("t5");
    check("t5_err_cleared", 32'(err_at1), 32'd0);
    check("t5_err_end", 32'(err_range), 32'd0);
    check("t5_idle_after", 32'(busy), 32'd0);

    // Reset mid-pass
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({busy, done, err_range, coef_rd_en, out_valid, out_last}), 32'd0);
    check("rst_mid_data_addr", 32'({out_data, coef_rd_addr}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_done", 32'({done, busy}), 32'd0);
    end
    rst_n = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_stays_idle", 32'(busy), 32'd0);

    // Last coefficient of the last polynomial
    clear_mem();
    mem[NCOEF-1] = -2;
    max_addr = 0;
    run_pass(100, 0);
    check_stream("t6");
    check("t6_final_byte", 32'(got_q[NPAIR-1]), 32'h64);
    check("t6_final_last", 32'(last_q[NPAIR-1]), 32'd1);
    check("t6_max_addr", 32'(max_addr), 32'd2815);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
